// File: rtl/vespa_loop_pkg.sv
// Shared definitions for the LOOP/CONTROL shift-register sequencer:
// state encodings, default sizes and a constant clog2 helper.
package vespa_loop_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PASS_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vespa_loop_sr_shadow.sv
// Shadow (outgoing) and capture (returning) registers of the SR sequencer.
// Ports: clk/rst; load_i/shift_i/recirc_i controls; load_data_i word;
// sr_ret_i chain tail bit; sr_bit_d_o next outgoing bit; capture_o word.
module vespa_loop_sr_shadow
    import vespa_loop_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             recirc_i,
    input  logic             sr_ret_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             sr_bit_d_o,
    output logic [WIDTH-1:0] capture_o
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] capture_q, capture_d;

    always_comb begin
        shadow_d  = shadow_q;
        capture_d = capture_q;
        if (load_i) begin
            shadow_d = load_data_i;
        end else if (recirc_i) begin
            // next pass sends out what came back on the previous one
            shadow_d = capture_q;
        end else if (shift_i) begin
            shadow_d = shadow_q >> 1;
        end
        if (shift_i) begin
            capture_d = {sr_ret_i, capture_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            capture_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            capture_q <= capture_d;
        end
    end

    // the registered sr_o needs the bit that will be at the head next cycle
    assign sr_bit_d_o = shadow_d[0];
    assign capture_o  = capture_q;

endmodule

// File: rtl/vespa_loop_sr_seq.sv
// Sequencer for the LOOP/CONTROL serial chain: loads a word, shifts it out
// LSB-first while capturing the tail, recirculates for multiple passes.
// Ports: start_valid/start_ready handshake with load_data/cfg_passes; abort;
// sr_o/sr_en to chain head, sr_ret from tail; busy/done/result status;
// CELV/CELG/CELSUB supply pins with no logic function.
module vespa_loop_sr_seq
    import vespa_loop_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  load_data,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              abort,
    output logic              sr_o,
    output logic              sr_en,
    input  logic              sr_ret,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              CELSUB
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic                sr_en_q, sr_o_q;
    logic [WIDTH-1:0]    result_q;
    logic                hs;
    logic                sr_bit_d;
    logic [WIDTH-1:0]    capture;
    logic                unused_supply;

    assign unused_supply = CELV ^ CELG ^ CELSUB;

    assign start_ready = (state_q == ST_IDLE) & ~abort & ~rst;
    assign hs          = start_valid & start_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        passes_d  = passes_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    passes_d  = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != LAST_BIT) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (passes_q > PASS_W'(1)) begin
                    state_d  = ST_GAP;
                    passes_d = passes_q - PASS_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                state_d   = ST_SHIFT;
                bit_cnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    vespa_loop_sr_shadow #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hs),
        .shift_i    (state_q == ST_SHIFT),
        .recirc_i   (state_q == ST_GAP),
        .sr_ret_i   (sr_ret),
        .load_data_i(load_data),
        .sr_bit_d_o (sr_bit_d),
        .capture_o  (capture)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            passes_q  <= '0;
            sr_en_q   <= 1'b0;
            sr_o_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            passes_q  <= passes_d;
            sr_en_q   <= (state_d == ST_SHIFT);
            sr_o_q    <= (state_d == ST_SHIFT) & sr_bit_d;
            if (state_q == ST_DONE && !abort) begin
                result_q <= capture;
            end
        end
    end

    assign sr_en  = sr_en_q;
    assign sr_o   = sr_o_q;
    assign busy   = (state_q == ST_SHIFT) | (state_q == ST_GAP);
    assign done   = (state_q == ST_DONE) & ~abort;
    assign result = result_q;

endmodule

// File: tb/tb_vespa_loop_sr_seq.sv
// Randomized bench for vespa_loop_sr_seq against a word-level model of the
// chain and of the pass/recirculate behaviour.
module tb_vespa_loop_sr_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] load_data;
    logic [3:0] cfg_passes;
    logic       abort;
    logic       sr_o;
    logic       sr_en;
    logic       sr_ret;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    logic [7:0] chain;
    logic [7:0] model_chain;
    logic [7:0] last_res;

    always #5 clk = ~clk;

    vespa_loop_sr_seq #(
        .WIDTH (8),
        .PASS_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .load_data  (load_data),
        .cfg_passes (cfg_passes),
        .abort      (abort),
        .sr_o       (sr_o),
        .sr_en      (sr_en),
        .sr_ret     (sr_ret),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .CELV       (1'b1),
        .CELG       (1'b0),
        .CELSUB     (1'b0)
    );

    // physical chain: WIDTH-stage shift register, tail at bit 0
    always @(posedge clk) begin
        if (sr_en) chain <= {sr_o, chain[7:1]};
    end
    assign sr_ret = chain[0];

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // chain after n LSB-first shifts of word w
    function automatic logic [7:0] shifted(input logic [7:0] w,
                                           input logic [7:0] c, input int n);
        logic [15:0] t;
        t = {w, c} >> n;
        return t[7:0];
    endfunction

    task automatic handshake(input logic [7:0] w, input logic [3:0] p);
        expect_eq("ready", {31'd0, start_ready}, 1);
        start_valid = 1'b1;
        load_data   = w;
        cfg_passes  = p;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        load_data   = 8'($urandom);
        cfg_passes  = 4'($urandom);
    endtask

    // called at a negedge in IDLE; returns at the negedge after DONE
    task automatic run_seq(input logic [7:0] w, input logic [3:0] p);
        logic [7:0]  pw [16];
        logic [7:0]  ch, cur, res;
        logic [11:0] ev;
        int np, k, j;
        np  = (p == 0) ? 1 : int'(p);
        ch  = model_chain;
        cur = w;
        res = '0;
        for (int i = 0; i < np; i++) begin
            pw[i] = cur;
            res   = ch;
            ch    = cur;
            cur   = res;
        end
        handshake(w, p);
        for (int c = 1; c <= np * (W + 1); c++) begin
            @(negedge clk);
            k = (c - 1) / (W + 1);
            j = (c - 1) % (W + 1);
            if (j < W)          ev = {last_res, 2'b11, pw[k][j], 1'b0};
            else if (k < np - 1) ev = {last_res, 4'b1000};
            else                ev = {last_res, 4'b0001};
            expect_eq($sformatf("seq w%h p%0d c%0d", w, p, c),
                      {20'd0, result, busy, sr_en, sr_o, done}, {20'd0, ev});
        end
        @(negedge clk);
        expect_eq("result", {24'd0, result}, {24'd0, res});
        expect_eq("idle", {28'd0, busy, sr_en, done, start_ready}, 4'b0001);
        model_chain = ch;
        last_res    = res;
    endtask

    // single pass aborted at the negedge of cycle ab (1..9)
    task automatic run_abort(input logic [7:0] w, input int ab);
        handshake(w, 4'd1);
        for (int c = 1; c <= ab; c++) @(negedge clk);
        abort = 1'b1;
        #1;
        expect_eq("abort_now", {29'd0, busy, done, start_ready},
                  {29'd0, (ab <= W), 2'b00});
        @(negedge clk);
        expect_eq("abort_next", {21'd0, result, busy, sr_en, done},
                  {21'd0, last_res, 3'b000});
        abort = 1'b0;
        model_chain = shifted(w, model_chain, (ab < W) ? ab : W);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            expect_eq("abort_quiet", {28'd0, busy, sr_en, done, start_ready},
                      4'b0001);
        end
    endtask

    task automatic run_reset(input logic [7:0] w, input int at);
        handshake(w, 4'd1);
        for (int c = 1; c <= at; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        expect_eq("rst_out", {19'd0, result, sr_en, sr_o, busy, done, start_ready},
                  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_eq("rst_ready", {31'd0, start_ready}, 1);
        model_chain = shifted(w, model_chain, at - 1);
        last_res    = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        load_data   = '0;
        cfg_passes  = '0;
        abort       = 1'b0;
        chain       = '0;
        model_chain = '0;
        last_res    = '0;
        repeat (2) @(negedge clk);
        expect_eq("reset", {19'd0, result, sr_en, sr_o, busy, done, start_ready},
                  32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_seq(8'hA5, 4'd1);
        expect_eq("first_res", {24'd0, result}, 32'h00);
        run_seq(8'h3C, 4'd1);
        expect_eq("second_res", {24'd0, result}, 32'hA5);
        run_seq(8'h0F, 4'd2);
        expect_eq("two_pass_res", {24'd0, result}, 32'h0F);
        run_seq(8'h5A, 4'd0);

        run_abort(8'h96, 3);

        // abort together with start: no handshake
        abort       = 1'b1;
        start_valid = 1'b1;
        load_data   = 8'hFF;
        cfg_passes  = 4'd1;
        #1;
        expect_eq("abort_start_rdy", {31'd0, start_ready}, 0);
        @(negedge clk);
        expect_eq("abort_start_idle", {30'd0, busy, sr_en}, 0);
        abort       = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        expect_eq("abort_start_stay", {30'd0, busy, sr_en}, 0);

        run_abort(8'h71, 9);
        run_reset(8'hC3, 5);
        run_seq(8'h2B, 4'd1);

        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) begin
                load_data = 8'($urandom);
                @(negedge clk);
            end
            run_seq(8'($urandom), 4'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
